// File: rtl/pc_sequencer_pkg.sv
// Shared constants for the fetch PC sequencer: FSM state encoding,
// next-PC source selects and default address map.
package pc_sequencer_pkg;

  localparam logic RUN   = 1'b0;
  localparam logic REDIR = 1'b1;

  localparam logic [2:0] SRC_SEQ  = 3'd0;
  localparam logic [2:0] SRC_NPC  = 3'd1;
  localparam logic [2:0] SRC_EXC  = 3'd2;
  localparam logic [2:0] SRC_EPC  = 3'd3;
  localparam logic [2:0] SRC_HOLD = 3'd4;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] DEF_IM_LO    = 32'h0000_3000;
  localparam logic [31:0] DEF_IM_HI    = 32'h0000_6ffc;

endpackage

// File: rtl/pc_sequencer_range_check.sv
// Combinational address check: flags a word address that is misaligned
// or outside [LO, HI]. Also usable for the data-side address check.
module pc_range_check
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] LO = DEF_IM_LO,
  parameter logic [31:0] HI = DEF_IM_HI
) (
  input  logic [31:0] addr,
  output logic        bad
);

  assign bad = (addr[1:0] != 2'b00) | (addr < LO) | (addr > HI);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register with exception/eret/branch redirect priority and a
// one-cycle bubble after exception or eret redirects.
// Optional redirect counter enabled by defining PC_REDIR_CNT_EN.
//
// Handshake: there is no valid/ready pair here. stall is a level freeze
// from the hazard unit; exc_req and eret_req are single-cycle commit pulses
// that are always accepted, even while stalled, and assert flush in the
// same cycle. if_valid qualifies the instruction fetched at pc.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] EXC_PC   = DEF_EXC_PC,
  parameter logic [31:0] IM_LO    = DEF_IM_LO,
  parameter logic [31:0] IM_HI    = DEF_IM_HI
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        npc_take,
  input  logic [31:0] npc_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic        if_valid,
  output logic        flush,
  output logic        pc_adel,
  output logic [31:0] redir_cnt,
  output logic        dbg_state
);

  logic        state;
  logic        state_nxt;
  logic [2:0]  src;
  logic [31:0] pc_nxt;
  logic        range_bad;

  // Source selection; REDIR ignores npc_take since D is being flushed.
  always_comb begin
    src = SRC_SEQ;
    if (exc_req)              src = SRC_EXC;
    else if (eret_req)        src = SRC_EPC;
    else if (stall)           src = SRC_HOLD;
    else if (state == REDIR)  src = SRC_HOLD;
    else if (npc_take)        src = SRC_NPC;
  end

  always_comb begin
    pc_nxt = pc + 32'd4;
    case (src)
      SRC_NPC:  pc_nxt = npc_target;
      SRC_EXC:  pc_nxt = EXC_PC;
      SRC_EPC:  pc_nxt = epc & 32'hffff_fffc;
      SRC_HOLD: pc_nxt = pc;
      default:  pc_nxt = pc + 32'd4;
    endcase
  end

  always_comb begin
    state_nxt = RUN;
    if (exc_req || eret_req) state_nxt = REDIR;
    else if (stall)          state_nxt = state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= RESET_PC;
      state <= RUN;
    end else begin
      pc    <= pc_nxt;
      state <= state_nxt;
    end
  end

  assign flush     = exc_req | eret_req;
  assign if_valid  = (state == RUN);
  assign dbg_state = state;

  pc_range_check #(.LO(IM_LO), .HI(IM_HI)) u_range (
    .addr (pc),
    .bad  (range_bad)
  );

  assign pc_adel = if_valid & range_bad;

`ifdef PC_REDIR_CNT_EN
  logic [31:0] cnt_q;
  logic        redir_load;

  assign redir_load = (src == SRC_EXC) | (src == SRC_EPC) | (src == SRC_NPC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt_q <= 32'h0;
    else if (redir_load && cnt_q != 32'hffff_ffff)
      cnt_q <= cnt_q + 32'd1;
  end

  assign redir_cnt = cnt_q;
`else
  assign redir_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, branch, stall,
// exception/eret redirect with bubble, address error, wrap and reset.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        npc_take;
  logic [31:0] npc_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc;
  logic        if_valid;
  logic        flush;
  logic        pc_adel;
  logic [31:0] redir_cnt;
  logic        dbg_state;

  int tests_run;
  int tests_failed;
  logic [31:0] exp_cnt;
  logic [31:0] exp_q[$];

  pc_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .npc_take   (npc_take),
    .npc_target (npc_target),
    .exc_req    (exc_req),
    .eret_req   (eret_req),
    .epc        (epc),
    .pc         (pc),
    .if_valid   (if_valid),
    .flush      (flush),
    .pc_adel    (pc_adel),
    .redir_cnt  (redir_cnt),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs are changed and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bump_cnt();
`ifdef PC_REDIR_CNT_EN
    exp_cnt = exp_cnt + 32'd1;
`endif
  endtask

  task automatic check_state(input string tag, input logic [31:0] exp_pc,
                             input logic exp_valid, input logic exp_adel);
    check({tag, "_pc"}, pc, exp_pc);
    check({tag, "_valid"}, {31'd0, if_valid}, {31'd0, exp_valid});
    check({tag, "_adel"}, {31'd0, pc_adel}, {31'd0, exp_adel});
    check({tag, "_cnt"}, redir_cnt, exp_cnt);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_cnt      = 32'h0;
    reset      = 1'b0;
    stall      = 1'b0;
    npc_take   = 1'b0;
    npc_target = 32'h0;
    exc_req    = 1'b0;
    eret_req   = 1'b0;
    epc        = 32'h0;

    #12;
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_cnt", redir_cnt, 32'd0);
    check("rst_state", {31'd0, dbg_state}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;

    // sequential fetch scoreboard
    exp_q.push_back(32'h0000_3000);
    exp_q.push_back(32'h0000_3004);
    exp_q.push_back(32'h0000_3008);
    while (exp_q.size() > 0) begin
      check_state("seq", exp_q.pop_front(), 1'b1, 1'b0);
      check("seq_flush", {31'd0, flush}, 32'd0);
      if (exp_q.size() > 0) step();
    end

    // taken branch at 3008
    npc_take = 1'b1; npc_target = 32'h0000_3100;
    #1 check("br_flush", {31'd0, flush}, 32'd0);
    step(); bump_cnt();
    check_state("br", 32'h0000_3100, 1'b1, 1'b0);
    npc_take = 1'b0;
    step();
    check_state("br_seq", 32'h0000_3104, 1'b1, 1'b0);
    npc_take = 1'b1; npc_target = 32'h0000_3010;
    step(); bump_cnt();
    check_state("br2", 32'h0000_3010, 1'b1, 1'b0);

    // stall holds pc even with a taken branch pending
    stall = 1'b1; npc_take = 1'b1; npc_target = 32'h0000_3200;
    for (int i = 0; i < 3; i++) begin
      step();
      check_state("stall", 32'h0000_3010, 1'b1, 1'b0);
    end
    stall = 1'b0;
    step(); bump_cnt();
    check_state("stall_rel", 32'h0000_3200, 1'b1, 1'b0);
    npc_target = 32'h0000_3020;
    step(); bump_cnt();
    check_state("to3020", 32'h0000_3020, 1'b1, 1'b0);
    npc_take = 1'b0;

    // exception beats eret and stall
    exc_req = 1'b1; eret_req = 1'b1; stall = 1'b1; epc = 32'h0000_3046;
    #1 check("exc_flush", {31'd0, flush}, 32'd1);
    step(); bump_cnt();
    exc_req = 1'b0; eret_req = 1'b0;
    check_state("exc_bub", 32'h0000_4180, 1'b0, 1'b0);
    check("exc_state", {31'd0, dbg_state}, 32'd1);
    #1 check("exc_noflush", {31'd0, flush}, 32'd0);
    step();
    check_state("redir_stall", 32'h0000_4180, 1'b0, 1'b0);
    stall = 1'b0;
    step();
    check_state("exc_run", 32'h0000_4180, 1'b1, 1'b0);
    step();
    check_state("exc_seq", 32'h0000_4184, 1'b1, 1'b0);

    // eret masks low bits; npc_take ignored in bubble
    eret_req = 1'b1; epc = 32'h0000_3046;
    #1 check("eret_flush", {31'd0, flush}, 32'd1);
    step(); bump_cnt();
    eret_req = 1'b0; npc_take = 1'b1; npc_target = 32'h0000_5000;
    check_state("eret_bub", 32'h0000_3044, 1'b0, 1'b0);
    step();
    npc_take = 1'b0;
    check_state("eret_run", 32'h0000_3044, 1'b1, 1'b0);
    step();
    check_state("eret_seq", 32'h0000_3048, 1'b1, 1'b0);

    // out-of-range target raises pc_adel until exception
    npc_take = 1'b1; npc_target = 32'h0000_7000;
    step(); bump_cnt();
    npc_take = 1'b0;
    check_state("adel_hi", 32'h0000_7000, 1'b1, 1'b1);
    step();
    check_state("adel_hold", 32'h0000_7004, 1'b1, 1'b1);
    exc_req = 1'b1;
    step(); bump_cnt();
    exc_req = 1'b0;
    check_state("adel_exc", 32'h0000_4180, 1'b0, 1'b0);
    step();
    check_state("adel_clr", 32'h0000_4180, 1'b1, 1'b0);

    // misaligned target and boundary IM_HI
    npc_take = 1'b1; npc_target = 32'h0000_6ffc;
    step(); bump_cnt();
    check_state("im_hi", 32'h0000_6ffc, 1'b1, 1'b0);
    npc_target = 32'h0000_3002;
    step(); bump_cnt();
    check_state("misalign", 32'h0000_3002, 1'b1, 1'b1);

    // pc+4 wrap
    npc_target = 32'hffff_fffc;
    step(); bump_cnt();
    npc_take = 1'b0;
    check_state("wrap_pre", 32'hffff_fffc, 1'b1, 1'b1);
    step();
    check_state("wrap", 32'h0000_0000, 1'b1, 1'b1);

    // reset in the middle of a redirect bubble
    exc_req = 1'b1;
    step(); bump_cnt();
    exc_req = 1'b0;
    check("mid_state", {31'd0, dbg_state}, 32'd1);
    reset = 1'b0;
    #1;
    exp_cnt = 32'h0;
    check_state("mid_rst", 32'h0000_3000, 1'b1, 1'b0);
    check("mid_rst_state", {31'd0, dbg_state}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    check_state("post_rst", 32'h0000_3004, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
